// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_arbiter
//  Purpose  : N-master Wishbone classic-cycle arbiter. Round-robin priority,
//             grant held for one whole transfer. Optional bus-timeout recovery
//             is enabled by the macro WB_RR_ARBITER_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//    m_stb_i/m_cyc_i/m_we_i  per-master strobe / cycle / write enable
//    m_sel_i/m_adr_i/m_dat_i packed per-master byte selects, address, wdata
//                            (master k at [k*W +: W])
//    m_ack_o/m_err_o         per-master ack / timeout error
//    m_dat_o                 read data, broadcast to all masters
//    s_*_o / s_ack_i/s_dat_i shared slave port
//    grant_o                 registered one-hot grant
// ============================================================================
module wb_rr_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [N_MASTERS-1:0]      m_stb_i,
  input  logic [N_MASTERS-1:0]      m_cyc_i,
  input  logic [N_MASTERS-1:0]      m_we_i,
  input  logic [N_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [N_MASTERS*AW-1:0]   m_adr_i,
  input  logic [N_MASTERS*DW-1:0]   m_dat_i,
  output logic [N_MASTERS-1:0]      m_ack_o,
  output logic [N_MASTERS-1:0]      m_err_o,
  output logic [DW-1:0]             m_dat_o,
  output logic                      s_stb_o,
  output logic                      s_cyc_o,
  output logic                      s_we_o,
  output logic [DW/8-1:0]           s_sel_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  input  logic                      s_ack_i,
  input  logic [DW-1:0]             s_dat_i,
  output logic [N_MASTERS-1:0]      grant_o
);

  localparam int c_sw = DW / 8;
  localparam int c_iw = $clog2(N_MASTERS);

  generate
    if (N_MASTERS < 2 || N_MASTERS > 8 || (DW % 8) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
      $error("wb_rr_arbiter: illegal parameter value");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [c_iw-1:0]        last_q, last_d;

  logic [N_MASTERS-1:0]   req;
  logic [c_iw-1:0]        win_idx;
  logic [c_iw-1:0]        cand;
  logic                   win_vld;
  logic [c_iw-1:0]        gnt_idx;
  logic                   busy;
  logic                   to_hit;

  assign req     = m_stb_i & m_cyc_i;
  assign busy    = (state_q == ST_BUSY);
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  // Round-robin pick: first requester scanning upward from last+1 with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = c_iw'((int'(last_q) + i) % N_MASTERS);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Binary index of the one-hot grant.
  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_q[k]) gnt_idx = c_iw'(k);
    end
  end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // An ack in the timeout cycle wins, so the hit is qualified by ~s_ack_i.
  assign to_hit  = busy & ~s_ack_i & (cnt_q == 16'(TIMEOUT - 1));
  assign m_err_o = grant_q & {N_MASTERS{to_hit}};

  // Held at zero outside BUSY, so it is zero on every BUSY entry.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy)         cnt_d = '0;
    else if (!s_ack_i) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign to_hit  = 1'b0;
  assign m_err_o = '0;
`endif

  // Next-state logic. Ack is tested first so ack+abort counts as ack;
  // all three exits behave identically apart from the ack itself.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_BUSY;
          grant_d = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
        end
      end
      ST_BUSY: begin
        if (s_ack_i || !m_cyc_i[gnt_idx] || to_hit) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gnt_idx;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= c_iw'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Slave-side mux: everything zero unless a master holds the grant.
  always_comb begin
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (busy && grant_q[k]) begin
        s_stb_o = m_stb_i[k];
        s_cyc_o = m_cyc_i[k];
        s_we_o  = m_we_i[k];
        s_sel_o = m_sel_i[k*c_sw +: c_sw];
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
      end
    end
  end

  assign m_ack_o = busy ? (grant_q & {N_MASTERS{s_ack_i}}) : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_rr_arbiter
//  Purpose  : Self-checking bench for wb_rr_arbiter (4 masters, TIMEOUT=8).
//             Vector table, hand sequences for multi-cycle corners, and a
//             randomized run against an ownership-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      m_stb, m_cyc, m_we;
  logic [N*SW-1:0]   m_sel;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic [N-1:0]      m_ack, m_err, grant;
  logic [DW-1:0]     m_rdat;
  logic              s_stb, s_cyc, s_we, s_ack;
  logic [SW-1:0]     s_sel;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_wdat, s_rdat;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_stb_i(m_stb), .m_cyc_i(m_cyc), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_rdat),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m_stb = '0; m_cyc = '0; m_we = '0; m_sel = '0;
    m_adr = '0; m_dat = '0; s_ack = 1'b0; s_rdat = '0;
  endtask

  // Reset asserted between edges; leaves time at posedge+1 after release.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst grant", 64'(grant), 64'h0);
    chk("rst s_cyc", 64'(s_cyc), 64'h0);
    chk("rst m_ack", 64'(m_ack), 64'h0);
    chk("rst m_err", 64'(m_err), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_ack;
    logic         exp_cyc;
  } vec_t;

  vec_t tbl[28];

  // ---------------- reference model state ----------------
  int owner, last, cnt;

  task automatic model_reset();
    owner = -1; last = N - 1; cnt = 0;
  endtask

  task automatic model_check(input int cyc_no);
    logic [N-1:0]  e_gnt, e_ack, e_err;
    logic          e_stb, e_cyc, e_we;
    logic [SW-1:0] e_sel;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    e_gnt = '0; e_ack = '0; e_err = '0;
    e_stb = 1'b0; e_cyc = 1'b0; e_we = 1'b0;
    e_sel = '0; e_adr = '0; e_dat = '0;
    if (owner >= 0) begin
      e_gnt = N'(1) << owner;
      e_ack = s_ack ? e_gnt : '0;
      e_stb = m_stb[owner];
      e_cyc = m_cyc[owner];
      e_we  = m_we[owner];
      e_sel = m_sel[owner*SW +: SW];
      e_adr = m_adr[owner*AW +: AW];
      e_dat = m_dat[owner*DW +: DW];
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      if (!s_ack && cnt == TO - 1) e_err = e_gnt;
`endif
    end
    chk($sformatf("rnd%0d grant", cyc_no), 64'(grant), 64'(e_gnt));
    chk($sformatf("rnd%0d m_ack", cyc_no), 64'(m_ack), 64'(e_ack));
    chk($sformatf("rnd%0d m_err", cyc_no), 64'(m_err), 64'(e_err));
    chk($sformatf("rnd%0d s_ctl", cyc_no), 64'({s_stb, s_cyc, s_we, s_sel}),
        64'({e_stb, e_cyc, e_we, e_sel}));
    chk($sformatf("rnd%0d s_adr", cyc_no), 64'(s_adr), 64'(e_adr));
    chk($sformatf("rnd%0d s_dat", cyc_no), 64'(s_wdat), 64'(e_dat));
    chk($sformatf("rnd%0d m_dat", cyc_no), 64'(m_rdat), 64'(s_rdat));
  endtask

  // Advance the model across one clock edge using the held inputs.
  task automatic model_step();
    logic done;
    logic found;
    int   c;
    if (owner < 0) begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        c = (last + i) % N;
        if (!found && m_stb[c] && m_cyc[c]) begin
          found = 1'b1;
          owner = c;
          cnt   = 0;
        end
      end
    end else begin
      done = s_ack || !m_cyc[owner];
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      if (cnt == TO - 1) done = 1'b1;
`endif
      if (done) begin
        last  = owner;
        owner = -1;
      end else begin
        cnt++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();

    // ---------------- vector table ----------------
    tbl[0]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1};
    tbl[10] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[11] = '{4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1};
    tbl[12] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[13] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1};
    tbl[14] = '{4'b1010, 1'b0, 4'b0010, 4'b0000, 1'b1};
    tbl[15] = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1};
    tbl[16] = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[17] = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1};
    tbl[18] = '{4'b0100, 1'b0, 4'b1000, 4'b0000, 1'b0};
    tbl[19] = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[20] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1};
    tbl[21] = '{4'b1000, 1'b0, 4'b0100, 4'b0000, 1'b0};
    tbl[22] = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[23] = '{4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1};
    tbl[24] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[25] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[26] = '{4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0};
    tbl[27] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};

    do_reset();
    for (int r = 0; r < 28; r++) begin
      m_stb = tbl[r].req;
      m_cyc = tbl[r].req;
      s_ack = tbl[r].ack;
      #1;
      chk($sformatf("tbl%0d grant", r), 64'(grant), 64'(tbl[r].exp_gnt));
      chk($sformatf("tbl%0d m_ack", r), 64'(m_ack), 64'(tbl[r].exp_ack));
      chk($sformatf("tbl%0d s_cyc", r), 64'(s_cyc), 64'(tbl[r].exp_cyc));
      chk($sformatf("tbl%0d s_stb", r), 64'(s_stb), 64'(tbl[r].exp_cyc));
      chk($sformatf("tbl%0d m_err", r), 64'(m_err), 64'h0);
      step();
    end

    // ---------------- single request, 2 wait states ----------------
    do_reset();
    m_adr = {32'h4000_0030, 32'h3000_0010, 32'h2000_0020, 32'h1000_0040};
    m_stb = 4'b0100; m_cyc = 4'b0100; s_rdat = 32'hCAFE_0001;
    #1;
    chk("single idle s_adr", 64'(s_adr), 64'h0);
    chk("single m_dat", 64'(m_rdat), 64'hCAFE_0001);
    step();
    for (int w = 0; w < 3; w++) begin
      s_ack = (w == 2);
      #1;
      chk($sformatf("single w%0d s_adr", w), 64'(s_adr), 64'h3000_0010);
      chk($sformatf("single w%0d grant", w), 64'(grant), 64'b0100);
      chk($sformatf("single w%0d m_ack", w), 64'(m_ack), (w == 2) ? 64'b0100 : 64'h0);
      step();
    end
    m_stb = '0; m_cyc = '0; s_ack = 1'b0;
    #1;
    chk("single after grant", 64'(grant), 64'h0);
    step();

    // ---------------- slave never acks ----------------
    do_reset();
    m_stb = 4'b0001; m_cyc = 4'b0001;
    step();
    for (int b = 1; b <= TO; b++) begin
      #1;
      chk($sformatf("tmo b%0d s_cyc", b), 64'(s_cyc), 64'h1);
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      chk($sformatf("tmo b%0d m_err", b), 64'(m_err), (b == TO) ? 64'b0001 : 64'h0);
`else
      chk($sformatf("tmo b%0d m_err", b), 64'(m_err), 64'h0);
`endif
      step();
    end
    #1;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    chk("tmo after s_cyc", 64'(s_cyc), 64'h0);
`else
    chk("tmo after s_cyc", 64'(s_cyc), 64'h1);
`endif
    step();

    // ---------------- asynchronous reset mid-BUSY ----------------
    do_reset();
    m_stb = 4'b0010; m_cyc = 4'b0010;
    step();
    s_ack = 1'b0;
    step();
    m_stb = 4'b1111; m_cyc = 4'b1111; s_ack = 1'b1;
    #2;
    chk("arst pre m_ack", 64'(m_ack), 64'b0010);
    rst = 1'b1;
    #1;
    chk("arst s_stb", 64'(s_stb), 64'h0);
    chk("arst s_cyc", 64'(s_cyc), 64'h0);
    chk("arst grant", 64'(grant), 64'h0);
    chk("arst m_ack", 64'(m_ack), 64'h0);
    step();
    rst = 1'b0; s_ack = 1'b0;
    step();
    #1;
    chk("arst first winner", 64'(grant), 64'b0001);
    step();

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        m_stb[k] = ($urandom_range(0, 3) != 0);
        m_cyc[k] = ($urandom_range(0, 7) != 0);
        m_we[k]  = $urandom_range(0, 1) != 0;
      end
      m_sel  = 16'($urandom);
      m_adr  = {$urandom, $urandom, $urandom, $urandom};
      m_dat  = {$urandom, $urandom, $urandom, $urandom};
      s_rdat = $urandom;
      s_ack  = ($urandom_range(0, 2) == 0);
      #1;
      model_check(c);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised N-master Wishbone classic-cycle arbiter with round-robin priority, per-transfer grant locking and optional bus-timeout recovery. It sits between the CPU, the DMA engines and any further bus masters on one side, and the single shared user-project Wishbone slave port on the other. It replaces fixed two-master arbitration, so that adding a master needs only a parameter change.

## Interface
Parameters:
- N_MASTERS, 4, number of masters (2..8)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- TIMEOUT, 255, cycles in BUSY without ack before error (TIMEOUT_EN only; 1..65535)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- m_stb_i  in  N_MASTERS  per-master strobe
- m_cyc_i  in  N_MASTERS  per-master cycle
- m_we_i  in  N_MASTERS  per-master write enable
- m_sel_i  in  N_MASTERS*DW/8  byte selects; master k at slice [k*DW/8 +: DW/8]
- m_adr_i  in  N_MASTERS*AW  addresses; same slicing
- m_dat_i  in  N_MASTERS*DW  write data; same slicing
- m_ack_o  out  N_MASTERS  per-master ack
- m_err_o  out  N_MASTERS  per-master error (timeout)
- m_dat_o  out  DW  read data, broadcast to all masters
- s_stb_o, s_cyc_o, s_we_o  out  1  slave strobe, cycle, write enable
- s_sel_o  out  DW/8  slave byte selects
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_ack_i  in  1  slave ack
- s_dat_i  in  DW  slave read data
- grant_o  out  N_MASTERS  one-hot registered grant (debug/perf)

## Operation
- Request: req[k] = m_stb_i[k] & m_cyc_i[k].
- FSM states: IDLE, BUSY.
- IDLE: if any req, select winner k = first requester scanning from (last+1) mod N upward with wrap. Register grant_o = onehot(k), go to BUSY. Winner selection is combinational; grant is registered.
- BUSY: slave outputs mux from granted master. s_stb_o = m_stb_i[g], s_cyc_o = m_cyc_i[g]. m_ack_o[g] = s_ack_i, combinational. All other m_ack_o are 0.
- BUSY exits:
  - On s_ack_i: last <= g, grant cleared, go to IDLE.
  - If m_cyc_i[g] drops without ack (abort): go to IDLE, last <= g, no ack issued.
- IDLE drives all s_* outputs to 0. Requests arriving mid-BUSY wait; they are never dropped or reordered beyond round-robin.
- m_dat_o = s_dat_i at all times.
- Reset (any time, including mid-transfer): state IDLE, grant_o 0, last = N_MASTERS-1 (master 0 wins first), timeout counter 0. All s_* outputs, m_ack_o and m_err_o are 0. An in-flight slave cycle is abandoned.

## Timing
- Arbitration latency: req sampled at edge n; s_stb_o/s_cyc_o high from edge n+1.
- Zero-wait slave: ack in the first BUSY cycle gives m_ack_o in that same cycle. Sustained throughput is one transfer per 2 cycles (one IDLE gap between grants).
- Simultaneous ack and cyc-drop in the same cycle: treated as ack.
- A new request by the just-served master in the same cycle as its ack is not granted before the other pending requesters (fairness).
- With all N masters requesting continuously, each is served exactly once per N transfers.

## Configuration
- Macro: WB_RR_ARBITER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ack_i.
  - When the counter reaches TIMEOUT-1 with no ack, m_err_o[g] pulses for exactly that one cycle, s_stb_o/s_cyc_o are deasserted at the next edge, FSM goes to IDLE and last <= g.
  - An ack in the same cycle as the timeout takes precedence; no err is issued.
- Undefined: no counter is built, m_err_o is tied to 0, and BUSY waits indefinitely for ack or abort.

## Test plan
- Reset then single request: m_stb_i/m_cyc_i = 4'b0100, adr 0x3000_0010, slave acks after 2 wait cycles -> s_adr_o = 0x3000_0010 from edge 1; m_ack_o = 4'b0100 only in the ack cycle; grant_o = 4'b0100.
- All four request continuously, zero-wait slave -> grant order 0,1,2,3,0,1. Each m_ack_o bit pulses once per 8 cycles; there is one IDLE cycle between grants.
- Master 1 busy, master 3 raises request mid-transfer -> master 3 not switched in; granted exactly 2 cycles after master 1's ack.
- Master 2 granted, drops m_cyc_i before ack -> FSM IDLE next cycle, no ack on any master; master 3 (if requesting) is granted next.
- TIMEOUT_EN, TIMEOUT = 8, slave never acks -> m_err_o[g] high for exactly one cycle at the 8th BUSY cycle, s_cyc_o low on the next cycle. Without the macro -> s_cyc_o held high and m_err_o = 0.
- wb_rst_i asserted asynchronously mid-BUSY -> s_stb_o, s_cyc_o, grant_o and m_ack_o are 0 immediately. After release, master 0 wins a 4-way contention.
